// File: rtl/dual_rail_pkg.sv
// Shared encodings and FSM state type for the dual-rail exhaustive sequencer.
package dual_rail_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  localparam logic [1:0] EXP_DC  = 2'b00;
  localparam logic [1:0] EXP_0   = 2'b01;
  localparam logic [1:0] EXP_1   = 2'b10;
  localparam logic [1:0] EXP_RSV = 2'b11;

  localparam logic [1:0] RES_OK       = 2'b00;
  localparam logic [1:0] RES_MISMATCH = 2'b01;
  localparam logic [1:0] RES_TIMEOUT  = 2'b10;
  localparam logic [1:0] RES_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StNullPh,
    StDataPh,
    StReport,
    StDone
  } state_e;

  // Reserved expectation codes behave as don't care.
  function automatic logic pair_ok(input logic [1:0] exp_code, input logic [1:0] pair);
    case (exp_code)
      EXP_0:   return pair == DR_0;
      EXP_1:   return pair == DR_1;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dual_rail_vector_sequencer_if.sv
// Host-side control/status and DUT-side rail bundle of the sequencer.
interface dual_rail_vector_sequencer_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1
);
  logic                 start;
  logic                 tbl_we;
  logic [N_IN-1:0]      tbl_addr;
  logic [2*N_OUT-1:0]   tbl_data;
  logic [N_IN-1:0]      dut_in_t;
  logic [N_IN-1:0]      dut_in_f;
  logic [N_OUT-1:0]     dut_out_t;
  logic [N_OUT-1:0]     dut_out_f;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        fail_count;
  logic [N_IN-1:0]      first_fail;
  logic                 res_valid;
  logic [N_IN-1:0]      res_line;
  logic [1:0]           res_code;

  modport slave (
    input  start, tbl_we, tbl_addr, tbl_data, dut_out_t, dut_out_f,
    output dut_in_t, dut_in_f, busy, done, pass, fail_count, first_fail,
           res_valid, res_line, res_code
  );

  modport master (
    output start, tbl_we, tbl_addr, tbl_data, dut_out_t, dut_out_f,
    input  dut_in_t, dut_in_f, busy, done, pass, fail_count, first_fail,
           res_valid, res_line, res_code
  );
endinterface

// File: rtl/dr_completion_detect.sv
// Stability-qualified NULL/DATA completion detector over a bundle of rail pairs.
module dr_completion_detect #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_restart,
  input  logic [WIDTH-1:0] i_rail_t,
  input  logic [WIDTH-1:0] i_rail_f,
  output logic             o_all_null,
  output logic             o_all_data,
  output logic             o_any_illegal
);
  localparam int unsigned CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CntMax = CW'(STABLE - 1);

  logic          w_raw_null, w_raw_data;
  logic [CW-1:0] r_null_cnt, r_data_cnt;

  assign w_raw_null    = ~|(i_rail_t | i_rail_f);
  assign w_raw_data    = &(i_rail_t ^ i_rail_f);
  assign o_any_illegal = |(i_rail_t & i_rail_f);

  // Counters hold the number of prior consecutive cycles the condition was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_null_cnt <= '0;
      r_data_cnt <= '0;
    end else if (i_restart) begin
      r_null_cnt <= '0;
      r_data_cnt <= '0;
    end else begin
      r_null_cnt <= !w_raw_null ? '0 : (r_null_cnt == CntMax) ? CntMax : r_null_cnt + 1'b1;
      r_data_cnt <= !w_raw_data ? '0 : (r_data_cnt == CntMax) ? CntMax : r_data_cnt + 1'b1;
    end
  end

  assign o_all_null = w_raw_null && (r_null_cnt == CntMax);
  assign o_all_data = w_raw_data && (r_data_cnt == CntMax);
endmodule

// File: rtl/dual_rail_vector_sequencer.sv
// Walks every input code through a dual-rail DUT with NULL/DATA alternation and
// grades each DATA result against a loadable expected table.
module dual_rail_vector_sequencer
  import dual_rail_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned STABLE  = 2
) (
  input logic                         clk,
  input logic                         rst,
  dual_rail_vector_sequencer_if.slave bus
);
  localparam int unsigned Lines = 2 ** N_IN;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [N_IN:0] FailMax = {1'b1, {N_IN{1'b0}}};

  state_e              r_state, w_state_d;
  logic [N_IN-1:0]     r_line;
  logic [TW-1:0]       r_tmo;
  logic [1:0]          r_code, w_code_d;
  logic [N_IN:0]       r_fail_cnt;
  logic [N_IN-1:0]     r_first_fail;
  logic                r_pass;
  logic [2*N_OUT-1:0]  r_tbl [Lines];
  logic [2*N_OUT-1:0]  w_exp;
  logic                w_match, w_restart, w_tmo_hit;
  logic                w_all_null, w_all_data, w_any_ill;

  dr_completion_detect #(
    .WIDTH (N_OUT),
    .STABLE(STABLE)
  ) u_detect (
    .clk          (clk),
    .rst          (rst),
    .i_restart    (w_restart),
    .i_rail_t     (bus.dut_out_t),
    .i_rail_f     (bus.dut_out_f),
    .o_all_null   (w_all_null),
    .o_all_data   (w_all_data),
    .o_any_illegal(w_any_ill)
  );

  always_ff @(posedge clk) begin
    if (r_state == StIdle && bus.tbl_we) r_tbl[bus.tbl_addr] <= bus.tbl_data;
  end

  assign w_exp = r_tbl[r_line];

  always_comb begin
    w_match = 1'b1;
    for (int j = 0; j < int'(N_OUT); j++) begin
      if (!pair_ok(w_exp[2*j +: 2], {bus.dut_out_t[j], bus.dut_out_f[j]})) w_match = 1'b0;
    end
  end

  assign w_tmo_hit = (r_tmo == TmoLast);
  // Any state change is a phase entry: both timeout and stability counts restart.
  assign w_restart = (w_state_d != r_state);

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    case (r_state)
      StIdle: if (bus.start) w_state_d = StNullPh;
      StNullPh: begin
        if (w_all_null) begin
          w_state_d = StDataPh;
        end else if (w_tmo_hit) begin
          w_state_d = StReport;
          w_code_d  = RES_TIMEOUT;
        end
      end
      StDataPh: begin
        if (w_any_ill) begin
          w_state_d = StReport;
          w_code_d  = RES_ILLEGAL;
        end else if (w_all_data) begin
          w_state_d = StReport;
          w_code_d  = w_match ? RES_OK : RES_MISMATCH;
        end else if (w_tmo_hit) begin
          w_state_d = StReport;
          w_code_d  = RES_TIMEOUT;
        end
      end
      StReport: w_state_d = (&r_line) ? StDone : StNullPh;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_line       <= '0;
      r_tmo        <= '0;
      r_code       <= RES_OK;
      r_fail_cnt   <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_code  <= w_code_d;
      if (w_restart) r_tmo <= '0;
      else if (!w_tmo_hit) r_tmo <= r_tmo + 1'b1;
      if (r_state == StIdle && bus.start) begin
        r_line       <= '0;
        r_fail_cnt   <= '0;
        r_first_fail <= '0;
        r_pass       <= 1'b0;
      end
      if (r_state == StReport) begin
        if (r_code != RES_OK) begin
          if (r_fail_cnt == '0) r_first_fail <= r_line;
          if (r_fail_cnt != FailMax) r_fail_cnt <= r_fail_cnt + 1'b1;
        end
        if (w_state_d == StDone) r_pass <= (r_code == RES_OK) && (r_fail_cnt == '0);
        else r_line <= r_line + 1'b1;
      end
    end
  end

  assign bus.dut_in_t   = (r_state == StDataPh) ? r_line : '0;
  assign bus.dut_in_f   = (r_state == StDataPh) ? ~r_line : '0;
  assign bus.busy       = (r_state != StIdle);
  assign bus.done       = (r_state == StDone);
  assign bus.pass       = r_pass;
  assign bus.fail_count = r_fail_cnt;
  assign bus.first_fail = r_first_fail;
  assign bus.res_valid  = (r_state == StReport);
  assign bus.res_line   = r_line;
  assign bus.res_code   = r_code;
endmodule
